// File: rtl/switch_debouncer.sv
// Switch debouncer: 2-FF synchronizer feeding a 4-state debounce FSM.
// d_out follows the raw switch only after the synchronized level has held
// for STABLE_CYCLES+1 consecutive edges; rise/fall pulse on the same edge.
module switch_debouncer #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;

    // Two-stage synchronizer for the asynchronous switch input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: any opposite sample in a WAIT state falls back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            d_out <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    cnt <= '0;
                    if (sync2) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        d_out <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    cnt <= '0;
                    if (!sync2) begin
                        state <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (sync2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        d_out <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Busy is a direct decode of the WAIT states
    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule
